// File: rtl/prirv32_fetch_unit.sv
// prirv32_fetch_unit
//   Instruction fetch stage feeding the decoder. Holds the fetch PC and issues
//   word reads over a req/gnt/rvalid handshake. Returned words are buffered with
//   their PCs in a small prefetch FIFO and presented downstream via valid/ready.
//   A redirect flushes the FIFO and marks every in-flight read as stale.
// Ports
//   clk_in, rst_n                    clock, async active-low reset
//   fetch_en_i                       1 = issuing allowed, 0 = pause issuing
//   imem_req_o/addr_o/gnt_i          request channel (addr held until gnt)
//   imem_rvalid_i/rdata_i            in-order read responses, one per grant
//   redirect_i/redirect_pc_i         single-cycle PC redirect
//   instr_valid_o/ready_i            FIFO head handshake to the decoder
//   instr_data_o/instr_pc_o          FIFO head word and its PC
module prirv32_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PAUSE} state_e;

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding, r_drop, r_fifo_cnt;
  logic [PW-1:0] r_tag_wp, r_tag_rp, r_fifo_wp, r_fifo_rp;
  logic [31:0]   r_tag_q     [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_hold_data, r_hold_pc;

  logic [CW:0]   w_credit_used;
  logic          w_grant, w_rsp, w_push, w_pop;

  // Credit counts both buffered words and reads still in flight, so every
  // granted read is guaranteed a FIFO slot when it returns.
  assign w_credit_used = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
  assign imem_req_o    = (r_state == ST_RUN) && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o   = r_fetch_pc;

  assign w_grant = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp   = imem_rvalid_i && (r_outstanding != '0);
  assign w_push  = w_rsp && (r_drop == '0) && !redirect_i;
  assign w_pop   = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (r_fifo_cnt != '0);
  // When empty the outputs keep the last presented word.
  assign instr_data_o  = instr_valid_o ? r_fifo_data[r_fifo_rp] : r_hold_data;
  assign instr_pc_o    = instr_valid_o ? r_fifo_pc[r_fifo_rp]   : r_hold_pc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (!fetch_en_i) w_state_nxt = ST_PAUSE;
      ST_PAUSE: if (fetch_en_i)  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fifo_cnt    <= '0;
      r_tag_wp      <= '0;
      r_tag_rp      <= '0;
      r_fifo_wp     <= '0;
      r_fifo_rp     <= '0;
      r_hold_data   <= '0;
      r_hold_pc     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_data   <= instr_data_o;
      r_hold_pc     <= instr_pc_o;
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
      if (w_grant) r_tag_wp <= r_tag_wp + PW'(1);
      if (w_rsp)   r_tag_rp <= r_tag_rp + PW'(1);

      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        // drop is always a subset of outstanding, so after a redirect every
        // read still in flight (including one granted this cycle) is stale.
        r_drop     <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
        r_fifo_cnt <= '0;
        r_fifo_wp  <= '0;
        r_fifo_rp  <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        if (w_push) r_fifo_wp <= r_fifo_wp + PW'(1);
        if (w_pop)  r_fifo_rp <= r_fifo_rp + PW'(1);
      end
    end
  end

  // Storage arrays need no reset: they are only read behind valid counters.
  always_ff @(posedge clk_in) begin
    if (w_grant) r_tag_q[r_tag_wp] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_data[r_fifo_wp] <= imem_rdata_i;
      r_fifo_pc[r_fifo_wp]   <= r_tag_q[r_tag_rp];
    end
  end

  rvalid_without_request: assert property (@(posedge clk_in) disable iff (!rst_n)
    !(imem_rvalid_i && (r_outstanding == '0)));

endmodule

// File: tb/tb_prirv32_fetch_unit.sv
// Directed bench for prirv32_fetch_unit. Memory returns ~addr one cycle after
// each grant. A second instance with RESET_PC=FFFF_FFF8 checks PC wrap.
module tb_prirv32_fetch_unit;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n, fetch_en_i, imem_gnt_i, imem_rvalid_i, redirect_i, instr_ready_i;
  logic [31:0] imem_rdata_i, redirect_pc_i;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_data_o, instr_pc_o;

  logic        req1, rvalid1, valid1;
  logic [31:0] addr1, rdata1, data1, pc1;

  int errs = 0, checks = 0;
  logic [31:0] mem_q[$], g_addr[$], pop_pc[$], pop_data[$], g1[$];
  bit rsp_hold = 1'b0;

  prirv32_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .fetch_en_i(fetch_en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_data_o(instr_data_o), .instr_pc_o(instr_pc_o));

  prirv32_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk_in(clk_in), .rst_n(rst_n), .fetch_en_i(1'b1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_gnt_i(1'b1),
    .imem_rvalid_i(rvalid1), .imem_rdata_i(rdata1),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(valid1), .instr_ready_i(1'b1),
    .instr_data_o(data1), .instr_pc_o(pc1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    g_addr.delete(); pop_pc.delete(); pop_data.delete(); g1.delete();
    step(2);
    rst_n = 1'b1;
  endtask

  // Memory model for the main instance: grants sampled mid-cycle, response
  // driven in the following cycle. Also logs grants and decoder pops.
  initial begin : mem0
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      imem_rvalid_i = 1'b0;
      if (!rst_n) mem_q.delete();
      else if (!rsp_hold && mem_q.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ~mem_q.pop_front();
      end
      @(negedge clk_in);
      if (rst_n && imem_req_o && imem_gnt_i) begin
        mem_q.push_back(imem_addr_o);
        g_addr.push_back(imem_addr_o);
      end
      if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
        pop_pc.push_back(instr_pc_o);
        pop_data.push_back(instr_data_o);
      end
    end
  end

  initial begin : mem1
    logic        pend;
    logic [31:0] pa;
    pend = 1'b0; pa = 32'h0; rvalid1 = 1'b0; rdata1 = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      rvalid1 = pend && rst_n;
      rdata1  = ~pa;
      pend    = 1'b0;
      @(negedge clk_in);
      if (rst_n && req1) begin
        pend = 1'b1;
        pa   = addr1;
        g1.push_back(addr1);
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_en_i = 1'b1; imem_gnt_i = 1'b1; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; instr_ready_i = 1'b1;
    step(2);
    chk("rst_req",   32'(imem_req_o), 32'h0);
    chk("rst_addr",  imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_data",  instr_data_o, 32'h0);
    chk("rst_pc",    instr_pc_o, 32'h0);

    // 1: streaming, first-word latency, address order
    rst_n = 1'b1;
    chk("t1_boot_req", 32'(imem_req_o), 32'h0);
    step;
    chk("t1_req",   32'(imem_req_o), 32'h1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    step;
    chk("t1_lat_v0", 32'(instr_valid_o), 32'h0);
    step;
    chk("t1_lat_v1", 32'(instr_valid_o), 32'h1);
    chk("t1_pc0",    instr_pc_o, 32'h0);
    chk("t1_data0",  instr_data_o, 32'hFFFF_FFFF);
    step(20);
    chk("t1_g0", g_addr[0], 32'h0);
    chk("t1_g1", g_addr[1], 32'h4);
    chk("t1_g2", g_addr[2], 32'h8);
    chk("t1_p0", pop_pc[0], 32'h0);
    chk("t1_p1", pop_pc[1], 32'h4);
    chk("t1_p2", pop_pc[2], 32'h8);
    chk("t1_d2", pop_data[2], 32'hFFFF_FFF7);
    // 5: wrap instance ran alongside
    chk("t5_g0", g1[0], 32'hFFFF_FFF8);
    chk("t5_g1", g1[1], 32'hFFFF_FFFC);
    chk("t5_g2", g1[2], 32'h0000_0000);

    // 2: backpressure fills FIFO, credit stops requests
    instr_ready_i = 1'b0;
    do_reset();
    step(10);
    chk("t2_ngnt",    32'(g_addr.size()), 32'd2);
    chk("t2_req_off", 32'(imem_req_o), 32'h0);
    chk("t2_valid",   32'(instr_valid_o), 32'h1);
    chk("t2_hold_pc", instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    step;
    chk("t2_req_on",  32'(imem_req_o), 32'h1);
    chk("t2_addr_on", imem_addr_o, 32'h8);
    step(12);
    chk("t2_p0", pop_pc[0], 32'h0);
    chk("t2_p1", pop_pc[1], 32'h4);
    chk("t2_p2", pop_pc[2], 32'h8);
    chk("t2_p3", pop_pc[3], 32'hC);

    // 3: redirect with two reads in flight
    rsp_hold = 1'b1;
    do_reset();
    step(5);
    chk("t3_ngnt", 32'(g_addr.size()), 32'd2);
    redirect_pc_i = 32'h0000_0102;
    redirect_i = 1'b1;
    step;
    redirect_i = 1'b0;
    rsp_hold = 1'b0;
    chk("t3_flush_v", 32'(instr_valid_o), 32'h0);
    chk("t3_addr",    imem_addr_o, 32'h100);
    step(10);
    chk("t3_g2", g_addr[2], 32'h100);
    chk("t3_p0", pop_pc[0], 32'h100);
    chk("t3_d0", pop_data[0], 32'hFFFF_FEFF);
    chk("t3_p1", pop_pc[1], 32'h104);

    // 4: redirect in the same cycle as rvalid and a grant
    do_reset();
    step;
    step;
    chk("t4_req_coinc", 32'(imem_req_o), 32'h1);
    redirect_pc_i = 32'h0000_0200;
    redirect_i = 1'b1;
    step;
    redirect_i = 1'b0;
    chk("t4_v_c3", 32'(instr_valid_o), 32'h0);
    chk("t4_addr", imem_addr_o, 32'h200);
    step;
    chk("t4_v_c4", 32'(instr_valid_o), 32'h0);
    step;
    chk("t4_v_c5", 32'(instr_valid_o), 32'h1);
    chk("t4_pc",   instr_pc_o, 32'h200);
    step(8);
    chk("t4_g1", g_addr[1], 32'h4);
    chk("t4_g2", g_addr[2], 32'h200);
    chk("t4_p0", pop_pc[0], 32'h200);
    chk("t4_p1", pop_pc[1], 32'h204);

    // 6: delayed grant, pause, reset mid-flight
    imem_gnt_i = 1'b0;
    do_reset();
    step;
    for (int i = 0; i < 3; i++) begin
      chk("t6_req_wait",  32'(imem_req_o), 32'h1);
      chk("t6_addr_wait", imem_addr_o, 32'h0);
      step;
    end
    imem_gnt_i = 1'b1;
    step;
    chk("t6_addr_next", imem_addr_o, 32'h4);
    fetch_en_i = 1'b0;
    imem_gnt_i = 1'b0;
    step;
    imem_gnt_i = 1'b1;
    chk("t6_pause_req", 32'(imem_req_o), 32'h0);
    step(5);
    chk("t6_pause_ngnt", 32'(g_addr.size()), 32'd1);
    chk("t6_pause_req2", 32'(imem_req_o), 32'h0);
    chk("t6_drain_p0",   pop_pc[0], 32'h0);
    fetch_en_i = 1'b1;
    step;
    chk("t6_resume_req",  32'(imem_req_o), 32'h1);
    chk("t6_resume_addr", imem_addr_o, 32'h4);
    step;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   32'(imem_req_o), 32'h0);
    chk("t6_rst_addr",  imem_addr_o, 32'h0);
    chk("t6_rst_valid", 32'(instr_valid_o), 32'h0);
    chk("t6_rst_data",  instr_data_o, 32'h0);
    chk("t6_rst_pc",    instr_pc_o, 32'h0);
    do_reset();
    step;
    chk("t6_refetch_req",  32'(imem_req_o), 32'h1);
    chk("t6_refetch_addr", imem_addr_o, 32'h0);
    step(6);
    chk("t6_refetch_g0", g_addr[0], 32'h0);
    chk("t6_refetch_p0", pop_pc[0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
